// File: rtl/uart_rx_fsm.sv
// Frame sequencer for the UART receive path: start detect, sampler/checker scheduling, result strobes.
// Define UART_RX_ERR_CNT_EN to add the saturating err_cnt output.
module uart_rx_fsm #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  bit_cnt,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  cnt_enable,
    output logic                  cnt_clr,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  frame_err
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(8);
    localparam logic [BIT_CNT_W-1:0] MAX_FRAME_BIT = BIT_CNT_W'(10);

    logic [2:0]            state_q, state_d;
    logic                  abortClr_q, abortClr_d;
    logic                  parSamp_q, stpSamp_q;
    logic                  parFlag_q, stpFlag_q;
    logic [PRESCALE_W-1:0] chkPt, lastPt;
    logic                  atChk, atLast, busy, overrun, startGlitch;

    assign chkPt  = (prescale >> 1) + PRESCALE_W'(2);
    assign lastPt = prescale - PRESCALE_W'(1);
    assign atChk  = (edge_cnt == chkPt);
    assign atLast = (edge_cnt == lastPt);
    assign busy   = (state_q == START) || (state_q == DATA) ||
                    (state_q == PARITY) || (state_q == STOP);
    // A bit count past the longest frame means the counter lost sync; bail out to IDLE.
    assign overrun     = busy && (bit_cnt > MAX_FRAME_BIT);
    assign startGlitch = (state_q == START) && atLast && strt_glitch;

    always_comb begin
        state_d    = state_q;
        abortClr_d = 1'b0;
        case (state_q)
            IDLE:    if (!RX_IN) state_d = START;
            START: begin
                if (startGlitch) begin
                    state_d    = IDLE;
                    abortClr_d = 1'b1;
                end else if (atLast) begin
                    state_d = DATA;
                end
            end
            DATA:    if (atLast && (bit_cnt == LAST_DATA_BIT)) state_d = PAR_EN ? PARITY : STOP;
            PARITY:  if (atLast) state_d = STOP;
            STOP:    if (atLast) state_d = DONE;
            DONE:    state_d = RX_IN ? IDLE : START;
            default: state_d = IDLE;
        endcase
        if (overrun) begin
            state_d    = IDLE;
            abortClr_d = 1'b1;
        end
    end

    // Checker results are valid the cycle after their strobe, so the strobe is delayed one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            abortClr_q <= 1'b0;
            parSamp_q  <= 1'b0;
            stpSamp_q  <= 1'b0;
            parFlag_q  <= 1'b0;
            stpFlag_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            abortClr_q <= abortClr_d;
            parSamp_q  <= par_chk_en;
            stpSamp_q  <= stp_chk_en;
            if ((state_d == START) && (state_q != START)) begin
                parFlag_q <= 1'b0;
                stpFlag_q <= 1'b0;
            end else begin
                if (parSamp_q && par_err) parFlag_q <= 1'b1;
                if (stpSamp_q && stp_err) stpFlag_q <= 1'b1;
            end
        end
    end

    assign cnt_enable  = !rst && busy;
    assign dat_samp_en = !rst && busy;
    assign cnt_clr     = rst || abortClr_q;
    assign strt_chk_en = !rst && (state_q == START)  && atChk;
    assign deser_en    = !rst && (state_q == DATA)   && atChk;
    assign par_chk_en  = !rst && (state_q == PARITY) && atChk;
    assign stp_chk_en  = !rst && (state_q == STOP)   && atChk;
    assign data_valid  = !rst && (state_q == DONE) && !(parFlag_q || stpFlag_q);
    assign frame_err   = !rst && (state_q == DONE) &&  (parFlag_q || stpFlag_q);

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] errCnt_q, errCnt_d;

    always_comb begin
        errCnt_d = errCnt_q;
        if ((frame_err || startGlitch) && (errCnt_q != 8'hFF)) errCnt_d = errCnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) errCnt_q <= 8'd0;
        else     errCnt_q <= errCnt_d;
    end

    assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Randomized frame-level bench for uart_rx_fsm: a cycle timeline built from frame arithmetic is the reference.
// Build with UART_RX_ERR_CNT_EN defined to also check err_cnt saturation.
`timescale 1ns/1ps
module tb_uart_rx_fsm;

    localparam int PW   = 6;
    localparam int BW   = 4;
    localparam int MAXC = 80000;

    localparam int E_EN = 8, E_SAMP = 7, E_CLR = 6, E_DESER = 5, E_STRT = 4;
    localparam int E_PAR = 3, E_STP = 2, E_DV = 1, E_FE = 0;

    logic          clk = 1'b0;
    logic          rst, RX_IN, PAR_EN, strt_glitch, par_err, stp_err;
    logic [PW-1:0] prescale;
    logic [PW-1:0] edge_cnt = '0;
    logic [BW-1:0] bit_cnt = '0;
    logic          cnt_enable, cnt_clr, dat_samp_en, deser_en, strt_chk_en;
    logic          par_chk_en, stp_chk_en, data_valid, frame_err;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    bit            lineA  [MAXC];
    bit            rstA   [MAXC];
    logic [PW-1:0] presA  [MAXC];
    bit            parEnA [MAXC];
    bit            sgA    [MAXC];
    bit            peA    [MAXC];
    bit            seA    [MAXC];
    bit            incA   [MAXC];
    bit [8:0]      expA   [MAXC];

    int checks = 0;
    int failures = 0;
    int curCyc = 0;
    int cur = 0;
    int planCursor = 0;
    int errModel = 0;
    int t0A, t0B, t0G, t0X, endCyc;

    uart_rx_fsm #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
        .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .strt_glitch(strt_glitch),
        .par_err(par_err), .stp_err(stp_err), .cnt_enable(cnt_enable), .cnt_clr(cnt_clr),
        .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
        .frame_err(frame_err)
`ifdef UART_RX_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the edge/bit counter that sits next to the FSM in the real receive path.
    always @(posedge clk) begin
        if (cnt_clr) begin
            bit_cnt  <= '0;
            edge_cnt <= '0;
        end else if (cnt_enable) begin
            if (edge_cnt == prescale - PW'(1)) begin
                edge_cnt <= '0;
                bit_cnt  <= (bit_cnt == (PAR_EN ? BW'(10) : BW'(9))) ? BW'(0) : bit_cnt + BW'(1);
            end else begin
                edge_cnt <= edge_cnt + PW'(1);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, curCyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int c);
        rst         = rstA[c];
        RX_IN       = lineA[c];
        PAR_EN      = parEnA[c];
        prescale    = presA[c];
        strt_glitch = sgA[c];
        par_err     = peA[c];
        stp_err     = seA[c];
    endtask

    // kind 0 = full frame, 1 = start glitch, 2 = reset pulse in bit 4 of the data phase.
    task automatic planFrame(input int gap, input int p, input bit par, input int kind,
                             input bit perr, input bit serr, input logic [7:0] data, output int t0);
        int n, chk, d, cutOff, endC, c, lc, sP, sS;
        bit lb, err;
        t0     = cur + gap;
        n      = par ? 11 : 10;
        chk    = p / 2 + 2;
        d      = t0 + 1 + n * p;
        sP     = t0 + 1 + 9 * p + chk;
        sS     = t0 + 1 + (n - 1) * p + chk;
        err    = (par && perr) || serr;
        cutOff = (kind == 2) ? t0 + 1 + 4 * p + chk : MAXC;
        endC   = (kind == 1) ? t0 + p + 1 : d;
        if (cutOff < endC) endC = cutOff;
        for (c = planCursor; c <= endC; c++) begin
            presA[c]  = PW'(p);
            parEnA[c] = par;
        end
        planCursor = endC + 1;
        if (kind == 1) begin
            for (int e = 0; e < p; e++) begin
                c = t0 + 1 + e;
                expA[c][E_EN]   = 1'b1;
                expA[c][E_SAMP] = 1'b1;
                if (e == chk) expA[c][E_STRT] = 1'b1;
            end
            for (c = t0; c <= endC; c++) sgA[c] = (c >= t0 + 2 + chk);
            for (c = t0; c < t0 + 3; c++) lineA[c] = 1'b0;
            expA[endC][E_CLR] = 1'b1;
            incA[endC] = 1'b1;
            cur = endC + 1;
        end else begin
            for (int b = 0; b < n; b++) begin
                if (b == 0)      lb = 1'b0;
                else if (b <= 8) lb = data[b-1];
                else if (b == 9 && par) lb = ^data;
                else             lb = 1'b1;
                for (int e = 0; e < p; e++) begin
                    lc = t0 + b * p + e;
                    if (lc < cutOff) lineA[lc] = lb;
                    c = lc + 1;
                    if (c < cutOff) begin
                        expA[c][E_EN]   = 1'b1;
                        expA[c][E_SAMP] = 1'b1;
                        if (e == chk) begin
                            if (b == 0)          expA[c][E_STRT]  = 1'b1;
                            else if (b <= 8)     expA[c][E_DESER] = 1'b1;
                            else if (b == n - 1) expA[c][E_STP]   = 1'b1;
                            else                 expA[c][E_PAR]   = 1'b1;
                        end
                    end
                end
            end
            for (c = t0; c <= endC; c++) begin
                sgA[c] = (c < t0 + 2 + chk);
                peA[c] = par ? ((c > sP) ? perr : !perr) : 1'b1;
                seA[c] = (c > sS) ? serr : !serr;
            end
            if (kind == 2) begin
                rstA[cutOff] = 1'b1;
                expA[cutOff][E_CLR] = 1'b1;
                cur = cutOff + 1;
            end else begin
                expA[d][E_DV] = !err;
                expA[d][E_FE] = err;
                incA[d + 1]   = err;
                cur = d;
            end
        end
    endtask

    initial begin
        int p, kind, t, deserCount;
        for (int c = 0; c < MAXC; c++) begin
            lineA[c] = 1'b1;
            presA[c] = PW'(8);
        end
        for (int c = 0; c < 4; c++) begin
            rstA[c] = 1'b1;
            expA[c][E_CLR] = 1'b1;
        end
        planCursor = 4;
        cur = 10;

        planFrame(0, 8, 1'b0, 0, 1'b0, 1'b0, 8'hA5, t0A);
        planFrame(3, 16, 1'b1, 0, 1'b1, 1'b0, 8'h5A, t0B);
        planFrame(2, 16, 1'b1, 0, 1'b0, 1'b0, 8'($urandom), t);
        planFrame(4, 8, 1'b0, 1, 1'b0, 1'b0, 8'h00, t0G);
        planFrame(2, 32, 1'b0, 0, 1'b0, 1'b1, 8'hC3, t0X);
        planFrame(0, 32, 1'b0, 0, 1'b0, 1'b0, 8'h3C, t);
        planFrame(3, 8, 1'b0, 2, 1'b0, 1'b0, 8'h81, t);
        for (int i = 0; i < 40 && cur < MAXC - 40000; i++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            kind = $urandom_range(0, 9);
            kind = (kind < 8) ? 0 : (kind == 8) ? 1 : 2;
            planFrame($urandom_range(0, 5), p, 1'($urandom), kind,
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 8'($urandom), t);
        end
`ifdef UART_RX_ERR_CNT_EN
        for (int i = 0; i < 300; i++) planFrame(0, 8, 1'b1, 0, 1'b1, 1'b0, 8'($urandom), t);
`endif
        endCyc = cur + 20;

        deserCount = 0;
        for (int c = t0A; c <= t0A + 81; c++) deserCount += int'(expA[c][E_DESER]);
        checkOutput("modelDeserCountA", deserCount, 8);
        checkOutput("modelDeserA25", expA[25][E_DESER], 1);
        checkOutput("modelValidA91", expA[91][E_DV], 1);
        checkOutput("modelParStrobeB", expA[t0B + 155][E_PAR], 1);
        checkOutput("modelFrameErrB", expA[t0B + 177][E_FE], 1);

        applyStimulus(0);
        for (int c = 0; c <= endCyc; c++) begin
            @(posedge clk);
            #1;
            curCyc = c;
            applyStimulus(c);
            @(negedge clk);
            checkOutput("outputs", {cnt_enable, dat_samp_en, cnt_clr, deser_en, strt_chk_en,
                                    par_chk_en, stp_chk_en, data_valid, frame_err}, expA[c]);
            if (c == t0A + 15)  checkOutput("deserA", deser_en, 1);
            if (c == t0A + 80)  checkOutput("validEarlyA", data_valid, 0);
            if (c == t0A + 81)  checkOutput("validA", data_valid, 1);
            if (c == t0B + 155) checkOutput("parStrobeB", par_chk_en, 1);
            if (c == t0B + 177) checkOutput("frameErrB", frame_err, 1);
            if (c == t0G + 9)   checkOutput("glitchClr", cnt_clr, 1);
            if (c == t0G + 10)  checkOutput("glitchClrEnd", cnt_clr, 0);
            if (c == t0X + 321) checkOutput("stopErrX", frame_err, 1);
            if (c > 0 && rstA[c-1]) errModel = 0;
            else if (incA[c] && errModel < 255) errModel++;
`ifdef UART_RX_ERR_CNT_EN
            checkOutput("errCnt", err_cnt, errModel);
`endif
        end
`ifdef UART_RX_ERR_CNT_EN
        checkOutput("errCntSat", err_cnt, 8'hFF);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
